// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master and the SRAM slave.
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, hsize, haddr, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, hsize, haddr, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: reads, byte/halfword/word writes, optional wait
// states and a two-cycle ERROR response for illegal transfers.
//
// state  | meaning
// S_OK   | idle or last data cycle; hready=1, OKAY
// S_WAIT | wait-state countdown; hready=0, OKAY
// S_ERR1 | first ERROR cycle; hready=0, hresp=1
// S_ERR2 | second ERROR cycle; hready=1, hresp=1, accepts next address
module ahb_sram_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic            hclk,
  input  logic            hresetn,
  ahb_sram_slave_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int WI_W  = ADDR_W - LB;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_OK, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_pend;
  logic [IDX_W-1:0]  wr_idx;
  logic [NB-1:0]     wr_be;
  logic              rd_pend;
  logic [IDX_W-1:0]  rd_idx;

  logic              hready_o, hresp_o;
  logic [DATA_W-1:0] hrdata_q;

  logic              accept, a_legal, wr_fire;
  logic [WI_W-1:0]   a_word;
  logic [NB-1:0]     a_be;
  logic              cap_now;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] wr_merged;

  // htrans[0] only separates NONSEQ from SEQ, which this slave treats alike
  logic unused_htrans0;
  assign unused_htrans0 = bus.htrans[0];

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    merge_lanes = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  assign accept  = hready_o && bus.hsel && bus.htrans[1];
  assign wr_fire = wr_pend && hready_o;

  // address-phase decode: word index, legality and selected byte lanes
  always_comb begin
    int off;
    int span;
    a_word  = bus.haddr[ADDR_W-1:LB];
    off     = int'(bus.haddr[LB-1:0]);
    span    = 1 << bus.hsize;
    a_legal = 1'b1;
    if (32'(a_word) >= DEPTH_U) a_legal = 1'b0;
    if (int'(bus.hsize) > LB) a_legal = 1'b0;
    else if ((off & (span - 1)) != 0) a_legal = 1'b0;
    a_be = '0;
    for (int i = 0; i < NB; i++) begin
      a_be[i] = (i >= off) && (i < off + span);
    end
  end

  // read capture point, with forwarding from a write completing on the same edge
  always_comb begin
    cap_now = 1'b0;
    cap_idx = rd_idx;
    if (WAIT_STATES == 0) begin
      cap_now = accept && a_legal && !bus.hwrite;
      cap_idx = a_word[IDX_W-1:0];
    end else begin
      cap_now = rd_pend && (state == S_WAIT) && (cnt == 4'd0);
    end
    cap_data = mem[cap_idx];
    if (wr_fire && (wr_idx == cap_idx)) cap_data = merge_lanes(cap_data, bus.hwdata, wr_be);
    wr_merged = merge_lanes(mem[wr_idx], bus.hwdata, wr_be);
  end

  // FSM state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_OK;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_OK, S_ERR2: begin
        state_nxt = S_OK;
        if (accept) begin
          if (!a_legal)             state_nxt = S_ERR1;
          else if (WAIT_STATES > 0) state_nxt = S_WAIT;
        end
      end
      S_WAIT:  state_nxt = (cnt == 4'd0) ? S_OK : S_WAIT;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_OK;
    endcase
  end

  // FSM outputs
  always_comb begin
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    case (state)
      S_WAIT:  hready_o = 1'b0;
      S_ERR1: begin hready_o = 1'b0; hresp_o = 1'b1; end
      S_ERR2:  hresp_o  = 1'b1;
      default: ;
    endcase
  end

  // wait-state down-counter
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                     cnt <= 4'd0;
    else if (accept && a_legal)       cnt <= WS_LOAD;
    else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // pending data-phase bookkeeping for the accepted transfer
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_pend <= 1'b0;
      wr_idx  <= '0;
      wr_be   <= '0;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
    end else if (accept) begin
      wr_pend <= a_legal && bus.hwrite;
      rd_pend <= a_legal && !bus.hwrite;
      wr_idx  <= a_word[IDX_W-1:0];
      rd_idx  <= a_word[IDX_W-1:0];
      wr_be   <= a_be;
    end else begin
      if (wr_fire) wr_pend <= 1'b0;
      if (cap_now) rd_pend <= 1'b0;
    end
  end

  // storage array, cleared on reset, written at write completion
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_fire) begin
      mem[wr_idx] <= wr_merged;
    end
  end

  // read data register, holds between reads
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)     hrdata_q <= '0;
    else if (cap_now) hrdata_q <= cap_data;
  end

  assign bus.hready = hready_o;
  assign bus.hresp  = hresp_o;
  assign bus.hrdata = hrdata_q;
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite SRAM slave: the next generation of the team's single-mode write-only AHB slave. It adds reads, byte/halfword writes via `hsize`, configurable wait states, and two-cycle ERROR responses for illegal transfers. It is the memory-mapped endpoint that `minitb_ahb_master` drives in miniTB smoke tests. The address and data paths are generic in width and depth.

## Interface
- `ADDR_W`, 8: haddr width (byte address).
- `DATA_W`, 32: bus width; legal values 32 or 64.
- `DEPTH`, 64: memory size in words of `DATA_W`.
- `WAIT_STATES`, 0: extra data-phase cycles with hready low per legal transfer, 0..15.
- `hclk  in  1`: clock; all state changes on rising edge.
- `hresetn  in  1`: asynchronous, active-low reset.
- `hsel  in  1`: slave select.
- `htrans  in  2`: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hwrite  in  1`: 1 write, 0 read.
- `hsize  in  3`: transfer size, log2 of bytes.
- `haddr  in  ADDR_W`: byte address.
- `hwdata  in  DATA_W`: write data, valid during the data phase.
- `hready  out  1`: transfer complete / bus ready.
- `hresp  out  1`: 0 OKAY, 1 ERROR.
- `hrdata  out  DATA_W`: read data.

## Operation
- Address phase is accepted at a rising edge when hready=1, hsel=1 and htrans[1]=1 (NONSEQ/SEQ).
- IDLE, BUSY and hsel=0 are ignored: zero-wait OKAY, no memory effect.
- Word index = haddr >> log2(DATA_W/8). Byte lane = low haddr bits.
- A transfer is illegal if any of the following holds:
  - word index >= DEPTH;
  - hsize > log2(DATA_W/8);
  - haddr is not aligned to 2^hsize.
- An illegal transfer gets an ERROR response with no memory access.
- Writes update only the 2^hsize byte lanes selected by the address. Other bytes keep their value.
- Reads return the full word; the master picks lanes.
- Memory is cleared to 0 on reset.
- FSM states:
  - OK: hready=1, hresp=0. This is the reset state.
  - WAIT: hready=0, hresp=0, counter running.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- FSM transitions:
  - OK→WAIT on an accepted legal transfer when WAIT_STATES>0.
  - OK stays in OK on a legal transfer when WAIT_STATES=0.
  - OK→ERR1 on an accepted illegal transfer.
  - WAIT→OK after WAIT_STATES cycles.
  - ERR1→ERR2 always.
  - ERR2 behaves as OK for accepting the next address phase.
- Counter: 4-bit, loaded with WAIT_STATES-1 on accept, decremented in WAIT. Leave WAIT when it reaches 0.
- Read-after-write: if a read's data is captured on the same edge a write to the same word completes, hrdata returns the merged (post-write) word.

## Timing
- Reset values: hready=1, hresp=0, hrdata=0, FSM=OK, write pending cleared, memory all 0.
- Reset asserted mid-transfer aborts it: pending write discarded, outputs return to reset values asynchronously.
- Legal transfer accepted at edge E:
  - the data phase occupies cycles E..E+WAIT_STATES;
  - hready is low for the first WAIT_STATES cycles and high in the last;
  - completion is at edge E+WAIT_STATES+1.
- Write: hwdata is sampled at the completion edge. A read one cycle later observes the new data.
- Read: hrdata is valid throughout the hready=1 cycle of the data phase.
  - Capture is at E when WAIT_STATES=0.
  - Otherwise capture is at the edge that enters the final data cycle.
- hrdata holds its last read value at all other times.
- Error: ERR1 for one cycle after E, then ERR2 for one cycle. No wait states are inserted.
- Back-to-back: the next address phase may be accepted on any edge where hready=1, including the completion edge and the ERR2 cycle. Throughput is one transfer per WAIT_STATES+1 cycles.

## Test plan
- Reset check, all defaults: hready=1, hresp=0, hrdata=0. Then a 32-bit NONSEQ write of 0x5A5A5A5A to 0x0C followed by a read of 0x0C gives hrdata=0x5A5A5A5A with hready=1 in the data phase, OKAY.
- Byte write of 0xAB to 0x0D (hsize=0) over a word holding 0x11223344, then a word read of 0x0C → 0x1122AB44. Halfword write to 0x0E with data 0xBEEF0000 → 0xBEEFAB44.
- WAIT_STATES=3, write then read of 0x10: hready is low for exactly 3 cycles per transfer, and each transfer completes on the 4th data-phase cycle.
- Back-to-back write 0x99→addr 0x20, then read 0x20 in the next cycle (WAIT_STATES=0): the read returns 0x99 via forwarding. Ten back-to-back writes land at consecutive words.
- Illegal transfers: word index DEPTH, misaligned halfword at 0x01, and hsize=3 on a 32-bit bus. Each gives ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1), and memory is unchanged on readback.
- hresetn pulsed low during the WAIT state of a write to 0x08: outputs return to reset values immediately, and a read of 0x08 after reset returns 0.
